// File: rtl/key_irq_pkg.sv
// rtl/key_irq_pkg.sv - shared register offsets and default debounce length for key_debounce_irq
package key_irq_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 1000000;

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - one key: 2-flop synchronizer, debounce counter, stable state and press pulse
module key_debounce_cell
  import key_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_state,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic [1:0]    r_vld;
  logic          r_stable;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_accept;

  assign w_differ = r_sync1 ^ r_stable;
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  // Synchronizer flops hold the inverted key so their cleared value means "released".
  // r_vld marks when r_sync1 reflects the real pin; a key held through reset never arms.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_vld    <= 2'b00;
      r_stable <= 1'b0;
      r_armed  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync0 <= ~i_key_n;
      r_sync1 <= r_sync0;
      r_vld   <= {r_vld[0], 1'b1};
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= ~r_stable;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_vld[1] && !r_sync1 && !r_stable) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_state = r_stable;
  assign o_press = w_accept && !r_stable && r_armed;

endmodule

// File: rtl/key_debounce_irq.sv
// rtl/key_debounce_irq.sv - debounced push-buttons with Avalon-MM data/mask/edgecapture registers and irq
module key_debounce_irq
  import key_irq_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  output logic [N_KEYS-1:0] key_pressed
);

  logic [N_KEYS-1:0] w_state;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_clear;
  logic [N_KEYS-1:0] r_mask;
  logic [N_KEYS-1:0] r_edge;
  logic [31:0]       r_readdata;
  logic [31:0]       w_rd_mux;
  logic              r_irq;
  logic              w_unused_wdata;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .i_clk  (CLOCK_50),
      .i_rst  (reset),
      .i_key_n(key_n[g]),
      .o_state(w_state[g]),
      .o_press(w_press[g])
    );
  end

  assign w_unused_wdata = ^avs_writedata[31:N_KEYS];
  assign w_clear = (avs_write && avs_address == ADDR_EDGE) ? avs_writedata[N_KEYS-1:0] : '0;

  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      ADDR_DATA: w_rd_mux[N_KEYS-1:0] = w_state;
      ADDR_MASK: w_rd_mux[N_KEYS-1:0] = r_mask;
      ADDR_EDGE: w_rd_mux[N_KEYS-1:0] = r_edge;
      default:   w_rd_mux = '0;
    endcase
  end

  // Reads sample pre-write contents; a press in the clearing cycle survives the clear.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_mask     <= '0;
      r_edge     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (avs_write && avs_address == ADDR_MASK) begin
        r_mask <= avs_writedata[N_KEYS-1:0];
      end
      r_edge <= (r_edge & ~w_clear) | w_press;
      r_irq  <= |(r_edge & r_mask);
      if (avs_read) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;
  assign key_pressed  = w_state;

endmodule

// File: tb/tb_key_debounce_irq.sv
// tb/tb_key_debounce_irq.sv - directed bench for key_debounce_irq with DEBOUNCE_CYCLES=8
module tb_key_debounce_irq;

  logic        CLOCK_50;
  logic        reset;
  logic [3:0]  key_n;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [3:0]  key_pressed;

  int n_run;
  int n_fail;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  key_debounce_irq #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .key_n        (key_n),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq),
    .key_pressed  (key_pressed)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick(1);
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    tick(1);
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  logic [31:0] rd;

  initial begin
    n_run = 0;
    n_fail = 0;
    reset = 1'b1;
    key_n = 4'hF;
    avs_address = 2'd0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = 32'h0;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'hF};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 32'h5,         32'hF};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h5};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'hF,         32'h5};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h5};
    vecs[9]  = '{1'b1, 1'b0, 2'd1, 32'hF,         32'h5};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0};

    tick(3);
    reset = 1'b0;
    tick(5);

    // reset state
    check("rst readdata", avs_readdata, 32'h0);
    check("rst irq", {31'b0, irq}, 32'h0);
    check("rst key_pressed", {28'b0, key_pressed}, 32'h0);
    bus_read(2'd2, rd); check("rst mask", rd, 32'h0);
    bus_read(2'd3, rd); check("rst edge", rd, 32'h0);

    // register access table
    for (int i = 0; i < 14; i++) begin
      avs_write     = vecs[i].wr;
      avs_read      = vecs[i].rd;
      avs_address   = vecs[i].addr;
      avs_writedata = vecs[i].wdata;
      tick(1);
      avs_write     = 1'b0;
      avs_read      = 1'b0;
      avs_writedata = 32'h0;
      check($sformatf("vec%0d readdata", i), avs_readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d irq", i), {31'b0, irq}, 32'h0);
    end

    // clean press on key 1
    key_n[1] = 1'b0;
    tick(9);
    check("clean kp early", {28'b0, key_pressed}, 32'h0);
    tick(1);
    check("clean kp", {28'b0, key_pressed}, 32'h2);
    tick(10);
    bus_read(2'd3, rd); check("clean edge", rd, 32'h2);
    bus_read(2'd0, rd); check("clean data", rd, 32'h2);
    key_n[1] = 1'b1;
    tick(12);
    check("clean release kp", {28'b0, key_pressed}, 32'h0);
    bus_read(2'd3, rd); check("release no edge", rd, 32'h2);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, rd); check("clean cleared", rd, 32'h0);

    // bounce on key 0
    key_n[0] = 1'b0;
    tick(5);
    check("bounce kp early", {28'b0, key_pressed}, 32'h0);
    key_n[0] = 1'b1;
    tick(1);
    key_n[0] = 1'b0;
    tick(9);
    check("bounce kp before", {28'b0, key_pressed}, 32'h0);
    tick(1);
    check("bounce kp", {28'b0, key_pressed}, 32'h1);
    tick(2);
    bus_read(2'd3, rd); check("bounce edge", rd, 32'h1);
    key_n[0] = 1'b1;
    tick(12);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd); check("bounce cleared", rd, 32'h0);

    // irq with mask 0x4
    bus_write(2'd2, 32'h4);
    key_n[2] = 1'b0;
    tick(10);
    check("irq kp2", {28'b0, key_pressed}, 32'h4);
    check("irq not yet", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd);
    check("irq edge", rd, 32'h4);
    check("irq set", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h4);
    check("irq clear lag", {31'b0, irq}, 32'h1);
    tick(1);
    check("irq cleared", {31'b0, irq}, 32'h0);
    key_n[2] = 1'b1;
    tick(12);
    key_n[0] = 1'b0;
    tick(12);
    check("irq masked key0", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check("masked edge", rd, 32'h1);
    key_n[0] = 1'b1;
    tick(12);
    bus_write(2'd3, 32'h1);

    // clear collides with key 3 press acceptance
    bus_write(2'd2, 32'h8);
    key_n[3] = 1'b0;
    tick(9);
    bus_write(2'd3, 32'h8);
    check("coll kp3", {28'b0, key_pressed}, 32'h8);
    bus_read(2'd3, rd);
    check("coll edge", rd, 32'h8);
    check("coll irq", {31'b0, irq}, 32'h1);
    tick(3);
    check("coll irq hold", {31'b0, irq}, 32'h1);

    // reset mid-count with edgecapture = 0xF
    key_n = 4'h0;
    tick(12);
    key_n = 4'hF;
    tick(12);
    bus_read(2'd3, rd); check("pre-reset edge", rd, 32'hF);
    key_n[1] = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("post rst readdata", avs_readdata, 32'h0);
    check("post rst irq", {31'b0, irq}, 32'h0);
    check("post rst kp", {28'b0, key_pressed}, 32'h0);
    bus_read(2'd2, rd); check("post rst mask", rd, 32'h0);
    bus_read(2'd3, rd); check("post rst edge", rd, 32'h0);
    bus_read(2'd0, rd); check("post rst data", rd, 32'h0);
    tick(6);
    check("held kp early", {28'b0, key_pressed}, 32'h0);
    tick(1);
    check("held kp", {28'b0, key_pressed}, 32'h2);
    tick(2);
    bus_read(2'd3, rd); check("held no edge", rd, 32'h0);
    check("held irq", {31'b0, irq}, 32'h0);
    key_n[1] = 1'b1;
    tick(12);
    key_n[1] = 1'b0;
    tick(12);
    bus_read(2'd3, rd); check("repress edge", rd, 32'h2);
    key_n[1] = 1'b1;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
